// File: rtl/half_adder_pkg.sv
// Shared constants and the per-lane result type for the half adder.
package half_adder_pkg;

  localparam int unsigned HA_WIDTH_DEFAULT   = 1;
  localparam bit          HA_REG_OUT_DEFAULT = 1'b1;

  // Lane result ordered so that {carry,sum} reads as the 2-bit sum a+b.
  typedef struct packed {
    logic carry;
    logic sum;
  } ha_bit_t;

endpackage

// File: rtl/half_adder_if.sv
// Addend/result bundle for the half adder; master drives A/B, slave returns SUM/CARRY.
interface half_adder_if
  import half_adder_pkg::*;
#(
  parameter int unsigned WIDTH = HA_WIDTH_DEFAULT
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] SUM;
  logic [WIDTH-1:0] CARRY;

  modport master (output A, output B, input SUM, input CARRY);
  modport slave  (input A, input B, output SUM, output CARRY);

endinterface

// File: rtl/half_adder_cell.sv
// One combinational half-adder lane: sum = a^b, carry = a&b.
module half_adder_cell
  import half_adder_pkg::*;
(
  input  logic    i_a,
  input  logic    i_b,
  output ha_bit_t o_res
);

  assign o_res.sum   = i_a ^ i_b;
  assign o_res.carry = i_a & i_b;

endmodule

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes; REG_OUT=1 adds one output register with sync reset.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int unsigned WIDTH   = HA_WIDTH_DEFAULT,
  parameter bit          REG_OUT = HA_REG_OUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  half_adder_if.slave bus
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_carry;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    ha_bit_t w_res;

    half_adder_cell u_cell (
      .i_a   (bus.A[g]),
      .i_b   (bus.B[g]),
      .o_res (w_res)
    );

    assign w_sum[g]   = w_res.sum;
    assign w_carry[g] = w_res.carry;
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_carry;

    // Reset wins over A/B and discards whatever result was about to load.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sum   <= '0;
        r_carry <= '0;
      end else begin
        r_sum   <= w_sum;
        r_carry <= w_carry;
      end
    end

    assign bus.SUM   = r_sum;
    assign bus.CARRY = r_carry;
  end else begin : g_comb
    // clk/rst stay on the port list so both builds share one footprint.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst;

    assign bus.SUM   = w_sum;
    assign bus.CARRY = w_carry;
  end

endmodule

// File: tb/tb_half_adder.sv
// Directed table-driven bench for registered (W=1, W=4) and combinational (W=1) builds.
module tb_half_adder;

  logic clk = 1'b0;
  logic rst_r1, rst_r4, rst_c1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  half_adder_if #(.WIDTH(1)) if_r1 ();
  half_adder_if #(.WIDTH(4)) if_r4 ();
  half_adder_if #(.WIDTH(1)) if_c1 ();

  half_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_r1 (.clk(clk), .rst(rst_r1), .bus(if_r1));
  half_adder #(.WIDTH(4), .REG_OUT(1'b1)) u_r4 (.clk(clk), .rst(rst_r4), .bus(if_r4));
  half_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_c1 (.clk(clk), .rst(rst_c1), .bus(if_c1));

  typedef struct {
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_s;
    logic [3:0] exp_c;
  } vec_t;

  vec_t r1_tab [8];
  vec_t r4_tab [4];
  vec_t c1_tab [4];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [3:0] ra, rb, pa, pb, es, ec;
    logic [1:0] lane_sum;

    // rst, a, b, expected sum, expected carry (value seen one edge after applying)
    r1_tab[0] = '{1'b1, 4'h1, 4'h1, 4'h0, 4'h0};
    r1_tab[1] = '{1'b1, 4'h0, 4'h1, 4'h0, 4'h0};
    r1_tab[2] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0};
    r1_tab[3] = '{1'b0, 4'h0, 4'h1, 4'h1, 4'h0};
    r1_tab[4] = '{1'b0, 4'h1, 4'h0, 4'h1, 4'h0};
    r1_tab[5] = '{1'b0, 4'h1, 4'h1, 4'h0, 4'h1};
    r1_tab[6] = '{1'b1, 4'h1, 4'h1, 4'h0, 4'h0};
    r1_tab[7] = '{1'b0, 4'h1, 4'h1, 4'h0, 4'h1};

    r4_tab[0] = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
    r4_tab[1] = '{1'b0, 4'b1100, 4'b1010, 4'b0110, 4'b1000};
    r4_tab[2] = '{1'b0, 4'b1111, 4'b0001, 4'b1110, 4'b0001};
    r4_tab[3] = '{1'b0, 4'b0101, 4'b0101, 4'b0000, 4'b0101};

    c1_tab[0] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0};
    c1_tab[1] = '{1'b0, 4'h0, 4'h1, 4'h1, 4'h0};
    c1_tab[2] = '{1'b1, 4'h1, 4'h0, 4'h1, 4'h0};
    c1_tab[3] = '{1'b0, 4'h1, 4'h1, 4'h0, 4'h1};

    rst_r1 = 1'b1; rst_r4 = 1'b1; rst_c1 = 1'b0;
    if_r1.A = '0; if_r1.B = '0;
    if_r4.A = '0; if_r4.B = '0;
    if_c1.A = '0; if_c1.B = '0;
    @(negedge clk);

    // Registered W=1: reset, truth table at full rate, reset priority and release.
    for (int i = 0; i < 8; i++) begin
      rst_r1 = r1_tab[i].rst;
      if_r1.A = r1_tab[i].a[0];
      if_r1.B = r1_tab[i].b[0];
      @(negedge clk);
      check($sformatf("r1_sum[%0d]", i), 8'(if_r1.SUM), 8'(r1_tab[i].exp_s[0]));
      check($sformatf("r1_carry[%0d]", i), 8'(if_r1.CARRY), 8'(r1_tab[i].exp_c[0]));
    end

    // Reset raised between edges must not touch the outputs until the edge.
    rst_r1 = 1'b1; if_r1.A = 1'b1; if_r1.B = 1'b0;
    #1;
    check("r1_sync_rst_hold", 8'(if_r1.CARRY), 8'h1);
    @(negedge clk);
    check("r1_midstream_rst_s", 8'(if_r1.SUM), 8'h0);
    check("r1_midstream_rst_c", 8'(if_r1.CARRY), 8'h0);
    rst_r1 = 1'b0; if_r1.A = 1'b0; if_r1.B = 1'b0;
    @(negedge clk);
    check("r1_after_drop_s", 8'(if_r1.SUM), 8'h0);
    check("r1_after_drop_c", 8'(if_r1.CARRY), 8'h0);

    // Registered W=4: lanes stay independent.
    for (int i = 0; i < 4; i++) begin
      rst_r4 = r4_tab[i].rst;
      if_r4.A = r4_tab[i].a;
      if_r4.B = r4_tab[i].b;
      @(negedge clk);
      check($sformatf("r4_sum[%0d]", i), 8'(if_r4.SUM), 8'(r4_tab[i].exp_s));
      check($sformatf("r4_carry[%0d]", i), 8'(if_r4.CARRY), 8'(r4_tab[i].exp_c));
    end

    // Combinational W=1: outputs follow inputs at once; rst is ignored.
    for (int i = 0; i < 4; i++) begin
      rst_c1 = c1_tab[i].rst;
      if_c1.A = c1_tab[i].a[0];
      if_c1.B = c1_tab[i].b[0];
      #1;
      check($sformatf("c1_sum[%0d]", i), 8'(if_c1.SUM), 8'(c1_tab[i].exp_s[0]));
      check($sformatf("c1_carry[%0d]", i), 8'(if_c1.CARRY), 8'(c1_tab[i].exp_c[0]));
    end
    rst_c1 = 1'b0;

    // Random traffic: per-lane {C,S} == a+b one edge later, and S&C never both set.
    pa = 4'($urandom); pb = 4'($urandom);
    if_r4.A = pa; if_r4.B = pb;
    @(negedge clk);
    for (int k = 0; k < 1000; k++) begin
      for (int l = 0; l < 4; l++) begin
        lane_sum = 2'(pa[l]) + 2'(pb[l]);
        es[l] = lane_sum[0];
        ec[l] = lane_sum[1];
      end
      check("rand_r4_sum", 8'(if_r4.SUM), 8'(es));
      check("rand_r4_carry", 8'(if_r4.CARRY), 8'(ec));
      check("rand_r4_s_and_c", 8'(if_r4.SUM & if_r4.CARRY), 8'h0);

      ra = 4'($urandom); rb = 4'($urandom);
      if_r4.A = ra; if_r4.B = rb;
      if_c1.A = ra[0]; if_c1.B = rb[0];
      #1;
      lane_sum = 2'(ra[0]) + 2'(rb[0]);
      check("rand_c1", 8'({if_c1.CARRY, if_c1.SUM}), 8'(lane_sum));
      pa = ra; pb = rb;
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
